btb_param: RTL and testbench

- Parametrised branch target buffer for the IF/ID pipeline; successor of the single-counter BTB.
- Provides a combinational next-PC prediction for the IF-stage PC.
- Trains from resolved branches and jumps reported by the ID stage.
- Per-entry valid bits, full tag compare, jump marking, a flush input, and a selectable predictor mode: per-entry bimodal counters or a gshare pattern table with a global history register.

---
 rtl/btb_param.sv | 151 +++++++++++++++
 tb/tb_btb_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/btb_param.sv
// Direct-mapped branch target buffer with a combinational next-PC lookup for IF,
// trained by ID. The direction predictor is either per-entry bimodal or gshare.
module btb_param #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 8,
    parameter int PRED_MODE = 0,
    parameter int HIST_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] if_btb_pc,
    output logic                 if_btb_taken,
    output logic                 if_btb_hit,
    input  logic [WORD_SIZE-1:0] id_pc,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 bcond,
    input  logic [WORD_SIZE-1:0] target,
    input  logic                 flush
);
    localparam int DEPTH    = 1 << IDX_BITS;
    localparam int TAG_BITS = WORD_SIZE - IDX_BITS;

    logic                 valid_reg  [DEPTH];
    logic [TAG_BITS-1:0]  tag_reg    [DEPTH];
    logic [WORD_SIZE-1:0] target_reg [DEPTH];
    logic                 jump_reg   [DEPTH];

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] id_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic [TAG_BITS-1:0] id_tag;
    logic                update;
    logic [1:0]          pred_ctr;

    assign if_idx = if_pc[IDX_BITS-1:0];
    assign if_tag = if_pc[WORD_SIZE-1:IDX_BITS];
    assign id_idx = id_pc[IDX_BITS-1:0];
    assign id_tag = id_pc[WORD_SIZE-1:IDX_BITS];
    assign update = (branch || jump) && !flush;

    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? 2'b11 : c + 2'b01;
        else    return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg[gi]  <= 1'b0;
                    tag_reg[gi]    <= '0;
                    target_reg[gi] <= '0;
                    jump_reg[gi]   <= 1'b0;
                end else if (flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (update && id_idx == IDX_BITS'(gi)) begin
                    valid_reg[gi]  <= 1'b1;
                    tag_reg[gi]    <= id_tag;
                    target_reg[gi] <= target;
                    jump_reg[gi]   <= jump;
                end
            end
        end

        if (PRED_MODE == 0) begin : g_bimodal
            logic [1:0] ctr_reg [DEPTH];
            logic       id_hit;
            logic       ctr_we;
            logic [1:0] ctr_next;

            assign id_hit = valid_reg[id_idx] && (tag_reg[id_idx] == id_tag);

            // A jump only touches the counter when it allocates a fresh entry.
            always_comb begin
                ctr_we   = 1'b0;
                ctr_next = ctr_reg[id_idx];
                if (update) begin
                    if (jump) begin
                        ctr_we   = !id_hit;
                        ctr_next = 2'b11;
                    end else if (!id_hit) begin
                        ctr_we   = 1'b1;
                        ctr_next = bcond ? 2'b10 : 2'b01;
                    end else begin
                        ctr_we   = 1'b1;
                        ctr_next = sat_ctr(ctr_reg[id_idx], bcond);
                    end
                end
            end

            for (gi = 0; gi < DEPTH; gi++) begin : g_ctr
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)
                        ctr_reg[gi] <= 2'b00;
                    else if (ctr_we && id_idx == IDX_BITS'(gi))
                        ctr_reg[gi] <= ctr_next;
                end
            end

            assign pred_ctr = ctr_reg[if_idx];
        end else begin : g_gshare
            logic [HIST_BITS-1:0] ghr_reg;
            logic [HIST_BITS-1:0] ghr_next;
            logic [1:0]           pht_reg [DEPTH];
            logic [IDX_BITS-1:0]  ghr_ext;
            logic [IDX_BITS-1:0]  pht_wr_idx;
            logic                 pht_we;
            logic [1:0]           pht_next;

            assign ghr_ext    = IDX_BITS'(ghr_reg);
            assign pht_wr_idx = id_idx ^ ghr_ext;
            assign pht_we     = update && !jump;
            assign pht_next   = sat_ctr(pht_reg[pht_wr_idx], bcond);

            if (HIST_BITS == 1) begin : g_hist1
                assign ghr_next = bcond;
            end else begin : g_histn
                assign ghr_next = {ghr_reg[HIST_BITS-2:0], bcond};
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    ghr_reg <= '0;
                else if (flush)
                    ghr_reg <= '0;
                else if (pht_we)
                    ghr_reg <= ghr_next;
            end

            // PHT survives flush; only reset clears it.
            for (gi = 0; gi < DEPTH; gi++) begin : g_pht
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)
                        pht_reg[gi] <= 2'b00;
                    else if (pht_we && pht_wr_idx == IDX_BITS'(gi))
                        pht_reg[gi] <= pht_next;
                end
            end

            assign pred_ctr = pht_reg[if_idx ^ ghr_ext];
        end
    endgenerate

    assign if_btb_hit   = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
    assign if_btb_taken = if_btb_hit && (jump_reg[if_idx] || pred_ctr[1]);
    assign if_btb_pc    = if_btb_taken ? target_reg[if_idx] : if_pc + WORD_SIZE'(1);

endmodule

// File: tb/tb_btb_param.sv
// Drives a bimodal and a gshare (4-bit history) BTB with the same stream and
// compares both against an array-based model of the prediction/training rules.
module tb_btb_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] if_pc, id_pc, target;
    logic        branch, jump, bcond, flush;
    logic [15:0] pc_b, pc_g;
    logic        taken_b, taken_g, hit_b, hit_g;

    int n_cmp = 0;
    int n_err = 0;

    int m_valid [256];
    int m_tag   [256];
    int m_tgt   [256];
    int m_jump  [256];
    int m_ctr   [256];
    int m_pht   [256];
    int m_ghr;

    always #5 clk = ~clk;

    btb_param #(.WORD_SIZE(16), .IDX_BITS(8), .PRED_MODE(0), .HIST_BITS(8)) u_bim (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_btb_pc(pc_b),
        .if_btb_taken(taken_b), .if_btb_hit(hit_b), .id_pc(id_pc),
        .branch(branch), .jump(jump), .bcond(bcond), .target(target), .flush(flush));

    btb_param #(.WORD_SIZE(16), .IDX_BITS(8), .PRED_MODE(1), .HIST_BITS(4)) u_gsh (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_btb_pc(pc_g),
        .if_btb_taken(taken_g), .if_btb_hit(hit_g), .id_pc(id_pc),
        .branch(branch), .jump(jump), .bcond(bcond), .target(target), .flush(flush));

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
            m_jump[i] = 0; m_ctr[i] = 0; m_pht[i] = 0;
        end
        m_ghr = 0;
    endtask

    // Prediction as seen by IF, from the model's current (pre-edge) contents.
    task automatic check_all(input string name);
        int idx, tg, hit, tb, tgs;
        logic [15:0] seq_pc, epb, epg;
        idx = int'(if_pc) % 256;
        tg  = int'(if_pc) / 256;
        hit = (m_valid[idx] != 0 && m_tag[idx] == tg) ? 1 : 0;
        tb  = (hit != 0 && (m_jump[idx] != 0 || m_ctr[idx] >= 2)) ? 1 : 0;
        tgs = (hit != 0 && (m_jump[idx] != 0 || m_pht[idx ^ m_ghr] >= 2)) ? 1 : 0;
        seq_pc = 16'((int'(if_pc) + 1) % 65536);
        epb = (tb != 0) ? 16'(m_tgt[idx]) : seq_pc;
        epg = (tgs != 0) ? 16'(m_tgt[idx]) : seq_pc;
        $display("lookup %-10s pc=%h hit=%0d/%0d taken=%0d/%0d next=%h/%h",
                 name, if_pc, hit_b, hit_g, taken_b, taken_g, pc_b, pc_g);
        chk({name, ".bim_hit"},   16'(hit_b),   16'(hit));
        chk({name, ".bim_taken"}, 16'(taken_b), 16'(tb));
        chk({name, ".bim_pc"},    pc_b,         epb);
        chk({name, ".gsh_hit"},   16'(hit_g),   16'(hit));
        chk({name, ".gsh_taken"}, 16'(taken_g), 16'(tgs));
        chk({name, ".gsh_pc"},    pc_g,         epg);
    endtask

    task automatic model_update(input int ipc, input int br, input int jp, input int bc,
                                input int tgt, input int fl);
        int u, t, hit, p;
        if (fl != 0) begin
            for (int i = 0; i < 256; i++) m_valid[i] = 0;
            m_ghr = 0;
        end else if (br != 0 || jp != 0) begin
            u   = ipc % 256;
            t   = ipc / 256;
            hit = (m_valid[u] != 0 && m_tag[u] == t) ? 1 : 0;
            if (jp != 0) begin
                if (hit == 0) m_ctr[u] = 3;
            end else begin
                if (hit == 0) m_ctr[u] = (bc != 0) ? 2 : 1;
                else if (bc != 0) m_ctr[u] = (m_ctr[u] < 3) ? m_ctr[u] + 1 : 3;
                else m_ctr[u] = (m_ctr[u] > 0) ? m_ctr[u] - 1 : 0;
                p = u ^ m_ghr;
                if (bc != 0) m_pht[p] = (m_pht[p] < 3) ? m_pht[p] + 1 : 3;
                else m_pht[p] = (m_pht[p] > 0) ? m_pht[p] - 1 : 0;
                m_ghr = ((m_ghr * 2) + bc) % 16;
            end
            m_valid[u] = 1; m_tag[u] = t; m_tgt[u] = tgt; m_jump[u] = jp;
        end
    endtask

    // One clock: drive after the edge, check at the falling edge, retire at the next edge.
    task automatic cycle(input int ipc, input int idpc, input int br, input int jp,
                         input int bc, input int tgt, input int fl, input string name);
        if_pc = 16'(ipc); id_pc = 16'(idpc); branch = br[0]; jump = jp[0];
        bcond = bc[0]; target = 16'(tgt); flush = fl[0];
        @(negedge clk);
        check_all(name);
        @(posedge clk);
        #1;
        model_update(idpc, br, jp, bc, tgt, fl);
    endtask

    task automatic look(input int ipc, input string name);
        cycle(ipc, 0, 0, 0, 0, 0, 0, name);
    endtask

    initial begin
        reset = 1'b1; if_pc = 16'h0040; id_pc = '0; target = '0;
        branch = 0; jump = 0; bcond = 0; flush = 0;
        model_reset();
        #2;
        check_all("in_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        look(16'h0040, "rst_40");
        look(16'hFFFF, "rst_ffff");

        cycle(16'h0000, 16'h0123, 1, 0, 1, 16'h0200, 0, "alloc");
        cycle(16'h0123, 16'h0123, 1, 0, 0, 16'h0200, 0, "ctr10");
        cycle(16'h0123, 16'h0123, 1, 0, 0, 16'h0200, 0, "ctr01");
        look(16'h0123, "ctr00");
        for (int k = 0; k < 4; k++) cycle(16'h0123, 16'h0123, 1, 0, 1, 16'h0200, 0, "ctr_up");
        look(16'h0123, "ctr_sat");

        cycle(16'h0310, 16'h0310, 1, 1, 0, 16'h0050, 0, "jmp_wr");
        look(16'h0310, "jmp_rd");
        look(16'h0123, "post_jmp");

        cycle(16'h0123, 16'h0223, 1, 0, 1, 16'h0300, 0, "alias_wr");
        look(16'h0123, "alias_old");
        look(16'h0223, "alias_new");

        for (int k = 0; k < 3; k++) cycle(16'h0010, 16'h0010, 1, 0, 1, 16'h0400, 0, "gsh_tr");
        look(16'h0010, "gsh_rd");
        cycle(16'h0010, 16'h0020, 1, 0, 1, 16'h0500, 1, "flush");
        look(16'h0010, "fl_10");
        look(16'h0020, "fl_20");
        cycle(16'h0000, 16'h0013, 1, 0, 1, 16'h0700, 0, "pht_keep");
        look(16'h0013, "pht_keep_rd");

        // Same-cycle write/read, then reset asserted between edges.
        cycle(16'h0000, 16'h0045, 1, 1, 0, 16'h0800, 0, "pre_col");
        if_pc = 16'h0045; id_pc = 16'h0045; branch = 1; jump = 0; bcond = 1;
        target = 16'h0900; flush = 0;
        #2;
        check_all("collide");
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; branch = 0; jump = 0;
        look(16'h0045, "post_rst");
        look(16'h0123, "post_rst2");

        for (int k = 0; k < 600; k++) begin
            int ipc, idpc, br, jp;
            ipc  = int'($urandom_range(0, 2)) * 256 + 16 + int'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) ipc = int'($urandom_range(0, 65535));
            idpc = int'($urandom_range(0, 2)) * 256 + 16 + int'($urandom_range(0, 7));
            br   = int'($urandom_range(0, 1));
            jp   = ($urandom_range(0, 4) == 0) ? 1 : 0;
            cycle(ipc, idpc, br, jp, int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 65535)),
                  ($urandom_range(0, 39) == 0) ? 1 : 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
